// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter job scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} sched_state_e;

  // Index following idx in a ring of r requesters.
  function automatic int ring_next(input int idx, input int r);
    return (idx + 1) % r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first active request at or after ptr wins.
module rr_arbiter #(
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [R-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < R; i++) begin
      idx = (int'(ptr) + i) % R;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/counter_job_scheduler.sv
// Time-shares one external up/down/load counter between R requesters,
// running one job at a time from load to end-value match (or abort).
module counter_job_scheduler
  import counter_sched_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int R  = 4,
  localparam int IW = $clog2(R)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [R-1:0]    req,
  input  logic [R*N-1:0]  req_start,
  input  logic [R*N-1:0]  req_end,
  input  logic [R-1:0]    req_up,
  input  logic            pause,
  input  logic            abort,
  input  logic [N-1:0]    cnt_value,
  output logic            cnt_en,
  output logic            cnt_load,
  output logic            cnt_up,
  output logic [N-1:0]    cnt_load_val,
  output logic            busy,
  output logic [IW-1:0]   grant_id,
  output logic [R-1:0]    done,
  output logic            aborted
);

  sched_state_e  state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [N-1:0]  start_q, start_d;
  logic [N-1:0]  end_q, end_d;
  logic          up_q, up_d;
  logic          aborted_q, aborted_d;

  logic [R-1:0]  arb_grant;
  logic [IW-1:0] arb_idx;

  rr_arbiter #(.R(R)) u_arb (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      start_q   <= '0;
      end_q     <= '0;
      up_q      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      end_q     <= end_d;
      up_q      <= up_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    start_d      = start_q;
    end_d        = end_q;
    up_d         = up_q;
    aborted_d    = aborted_q;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_up       = 1'b0;
    cnt_load_val = '0;
    done         = '0;
    aborted      = 1'b0;
    busy         = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d   = arb_idx;
          start_d   = req_start[arb_idx*N +: N];
          end_d     = req_end[arb_idx*N +: N];
          up_d      = |(arb_grant & req_up);
          aborted_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_up = up_q;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_en       = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = start_q;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        cnt_up = up_q;
        // Abort beats the end match, and the match is still checked while paused.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_value == end_q) begin
          state_d = S_DONE;
        end else if (!pause) begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        done[grant_q] = 1'b1;
        aborted       = aborted_q;
        rr_ptr_d      = IW'(ring_next(int'(grant_q), R));
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_counter_job_scheduler.sv
// Bench for counter_job_scheduler: drives jobs against a behavioural counter
// and predicts every cycle from step-count arithmetic and a round-robin model.
module tb_counter_job_scheduler;

  localparam int N = 8;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [R-1:0]   req;
  logic [R*N-1:0] req_start;
  logic [R*N-1:0] req_end;
  logic [R-1:0]   req_up;
  logic           pause;
  logic           abort;
  logic [N-1:0]   cnt_value;
  logic           cnt_en;
  logic           cnt_load;
  logic           cnt_up;
  logic [N-1:0]   cnt_load_val;
  logic           busy;
  logic [1:0]     grant_id;
  logic [R-1:0]   done;
  logic           aborted;

  int checks   = 0;
  int failures = 0;
  int mdl_ptr  = 0;
  int mdl_last = 0;

  counter_job_scheduler #(.N(N), .R(R)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_start    (req_start),
    .req_end      (req_end),
    .req_up       (req_up),
    .pause        (pause),
    .abort        (abort),
    .cnt_value    (cnt_value),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_up       (cnt_up),
    .cnt_load_val (cnt_load_val),
    .busy         (busy),
    .grant_id     (grant_id),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  // The shared external counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_value <= '0;
    else if (cnt_en) cnt_value <= cnt_load ? cnt_load_val
                                           : (cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(cnt_en), 0);
    chk({tag, "_load"}, 32'(cnt_load), 0);
    chk({tag, "_up"}, 32'(cnt_up), 0);
    chk({tag, "_loadval"}, 32'(cnt_load_val), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant"}, 32'(grant_id), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
  endtask

  task automatic set_job(input int i, input logic [7:0] s, input logic [7:0] e, input logic up);
    req_start[i*N +: N] = s;
    req_end[i*N +: N]   = e;
    req_up[i]           = up;
    req[i]              = 1'b1;
  endtask

  task automatic rand_job(input int i);
    logic [7:0] s, d;
    logic       up;
    s  = 8'($urandom);
    d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 23));
    up = 1'($urandom_range(0, 1));
    set_job(i, s, up ? s + d : s - d, up);
  endtask

  // Entered just after the edge that opens the IDLE cycle in which req is seen.
  // pa/pl: pause window in RUN-cycle indices; ab: RUN index that raises abort.
  task automatic run_job(input int pa, input int pl, input int ab);
    int         g, s, nrun, tdone, k, pb;
    logic [7:0] st, en, v, d;
    logic       up, exp_ab, exp_en;
    g = -1;
    for (int i = 0; i < R; i++) begin
      int j;
      j = (mdl_ptr + i) % R;
      if (g < 0 && req[j]) g = j;
    end
    if (g < 0) return;
    st = req_start[g*N +: N];
    en = req_end[g*N +: N];
    up = req_up[g];
    d  = up ? en - st : st - en;
    s  = int'(d);
    if (pa < 0 || pa >= s) pl = 0;
    nrun   = s + 1 + pl;
    exp_ab = 1'b0;
    if (ab >= 0 && ab < nrun) begin
      nrun   = ab + 1;
      exp_ab = 1'b1;
    end
    tdone = 2 + nrun;
    $display("job g=%0d start=%0d end=%0d up=%0d steps=%0d pause=%0d@%0d abort=%0d done_cycle=%0d",
             g, st, en, up, s, pl, pa, exp_ab, tdone);

    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_en", 32'(cnt_en), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_grant_hold", 32'(grant_id), 32'(mdl_last));

    for (int c = 1; c <= tdone; c++) begin
      @(posedge clk);
      #1;
      k     = c - 2;
      pause = (pl > 0 && k >= pa && k < pa + pl);
      abort = exp_ab && (k == ab);
      @(negedge clk);
      chk("busy", 32'(busy), 1);
      chk("grant_id", 32'(grant_id), 32'(g));
      if (c == 1) begin
        chk("load_en", 32'(cnt_en), 1);
        chk("load_load", 32'(cnt_load), 1);
        chk("load_val", 32'(cnt_load_val), 32'(st));
        chk("load_up", 32'(cnt_up), 32'(up));
        chk("load_done", 32'(done), 0);
      end else if (c < tdone) begin
        pb     = (pl == 0 || k < pa) ? 0 : ((k - pa > pl) ? pl : k - pa);
        v      = up ? st + 8'(k - pb) : st - 8'(k - pb);
        exp_en = !(pause || abort || (k == nrun - 1));
        chk("run_value", 32'(cnt_value), 32'(v));
        chk("run_en", 32'(cnt_en), 32'(exp_en));
        chk("run_load", 32'(cnt_load), 0);
        chk("run_up", 32'(cnt_up), 32'(up));
        chk("run_done", 32'(done), 0);
      end else begin
        chk("done_pulse", 32'(done), 32'(1 << g));
        chk("done_aborted", 32'(aborted), 32'(exp_ab));
        chk("done_en", 32'(cnt_en), 0);
      end
    end
    @(posedge clk);
    #1;
    req[g]   = 1'b0;
    pause    = 1'b0;
    abort    = 1'b0;
    mdl_ptr  = (g + 1) % R;
    mdl_last = g;
  endtask

  initial begin
    int pa, pl, ab, guard;
    reset_n   = 1'b0;
    req       = '0;
    req_start = '0;
    req_end   = '0;
    req_up    = '0;
    pause     = 1'b0;
    abort     = 1'b0;
    #3;
    chk_all_zero("reset");
    #20;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    set_job(2, 8'd10, 8'd14, 1'b1);
    run_job(-1, 0, -1);

    set_job(1, 8'd250, 8'd3, 1'b1);
    run_job(-1, 0, -1);
    set_job(3, 8'd2, 8'd254, 1'b0);
    run_job(-1, 0, -1);

    for (int i = 0; i < R; i++) set_job(i, 8'(i * 7), 8'(i * 7 + i), 1'b1);
    mdl_ptr = 0;
    for (int i = 0; i < R; i++) run_job(-1, 0, -1);

    set_job(1, 8'd40, 8'd38, 1'b0);
    run_job(-1, 0, -1);
    set_job(0, 8'd100, 8'd103, 1'b1);
    set_job(3, 8'd7, 8'd5, 1'b0);
    run_job(-1, 0, -1);
    run_job(-1, 0, -1);

    set_job(2, 8'h55, 8'h55, 1'b1);
    run_job(-1, 0, -1);

    set_job(0, 8'd0, 8'd5, 1'b1);
    run_job(2, 3, -1);

    set_job(1, 8'd0, 8'd20, 1'b1);
    run_job(-1, 0, 1);

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < R; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) rand_job(i);
      if (req == '0) rand_job(int'($urandom_range(0, R - 1)));
      pa = -1;
      pl = 0;
      ab = -1;
      if ($urandom_range(0, 2) == 0) begin
        pa = int'($urandom_range(0, 7));
        pl = int'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 4) == 0) ab = int'($urandom_range(0, 9));
      run_job(pa, pl, ab);
    end
    guard = 0;
    while (req != '0 && guard < 8) begin
      run_job(-1, 0, -1);
      guard++;
    end
    chk("drain_req", 32'(req), 0);

    // Reset in the middle of RUN: outputs clear at once and no done follows.
    set_job(2, 8'd0, 8'd100, 1'b1);
    @(negedge clk);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_done", 32'(done), 0);
      chk("midreset_busy", 32'(busy), 0);
    end
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    mdl_ptr  = 0;
    mdl_last = 0;
    @(posedge clk);
    #1;
    set_job(1, 8'd9, 8'd11, 1'b1);
    run_job(-1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_job_scheduler.md
# counter_job_scheduler

Sequencing controller that time-shares one external N-bit up/down/load counter between R requesters. Each requester submits a counting job (start value, end value, direction); the scheduler grants jobs round-robin, drives the counter's enable/load/direction controls, and watches the counter's output until the end value is reached. It signals completion back to the owning requester. It sits between the requester blocks and the shared counter instance. Counter and scheduler share clk and reset_n.

## Interface
- N, 8: counter width; must equal the attached counter's width.
- R, 4: number of requesters, R ≥ 2; IW = $clog2(R).
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  R  per-requester job request, held high until that requester's done pulse.
- req_start  in  R*N  job start values, slice i = [i*N +: N]; stable while req[i] is high.
- req_end  in  R*N  job end values, same slicing.
- req_up  in  R  job direction: 1 = count up, 0 = count down.
- pause  in  1  freezes counting while high during RUN.
- abort  in  1  terminates the active job.
- cnt_value  in  N  counter output fed back.
- cnt_en  out  1  counter clock enable.
- cnt_load  out  1  counter load.
- cnt_up  out  1  counter direction.
- cnt_load_val  out  N  counter load value.
- busy  out  1  high in every state except IDLE.
- grant_id  out  IW  index of the active job; holds its last value in IDLE.
- done  out  R  one-cycle completion pulse to the owning requester.
- aborted  out  1  qualifies done: 1 = job ended by abort.

## Operation
- FSM states are IDLE, LOAD, RUN, DONE.
- IDLE
  - If any req bit is high, the arbiter picks winner g, starting the search at rr_ptr.
  - Latch start_g, end_g and up_g; set grant_id = g; go to LOAD.
  - req is sampled only in IDLE. Changes to req in other states are ignored.
- LOAD
  - Drive cnt_en = 1, cnt_load = 1, cnt_load_val = latched start, cnt_up = latched direction.
  - Go to RUN.
- RUN
  - If cnt_value == latched end: cnt_en = 0, go to DONE.
  - Else if pause: cnt_en = 0, stay in RUN.
  - Else: cnt_en = 1, cnt_load = 0, stay in RUN.
  - The end-value compare is evaluated even while paused.
- DONE
  - Pulse done[grant_id] for one cycle; aborted is valid in the same cycle.
  - Set rr_ptr = (grant_id + 1) mod R; go to IDLE.
- abort
  - In LOAD or RUN, abort forces the next state to DONE with aborted = 1.
  - cnt_en = 0 in that cycle.
  - abort takes priority over pause and over the end-value match.
  - abort is ignored in IDLE and DONE.
- Arithmetic
  - Counting is modulo 2^N and relies on the counter's natural wrap.
  - Steps for an up job: S = (end − start) mod 2^N. Steps for a down job: S = (start − end) mod 2^N.
  - start == end gives S = 0: zero counting cycles, and the job still completes.
- Reset values
  - State = IDLE, rr_ptr = 0.
  - All outputs = 0: cnt_en, cnt_load, cnt_up, cnt_load_val, busy, grant_id, done, aborted.
- Reset mid-job: return to IDLE immediately, with no done pulse. The requester must re-request.

## Timing
- Cycle numbering
  - Cycle 0: IDLE, req seen.
  - Cycle 1: LOAD.
  - Cycles 2..2+S: RUN, without pause.
  - Cycle 3+S: DONE, done pulse.
  - Cycle 4+S: IDLE, next grant possible.
- Request-to-done latency is 3+S cycles, plus one cycle per paused RUN cycle.
- In RUN cycle k (k counted from 0), cnt_value = start ± k.
- Back-to-back jobs: the minimum gap between consecutive done pulses is 4 cycles (when S = 0).
- Requester rule: drop req on the edge that follows done. Holding req longer re-enters arbitration in IDLE.

## Structure
- counter_sched_pkg holds typedef enum logic [1:0] sched_state_e {S_IDLE, S_LOAD, S_RUN, S_DONE}.
- Sub-module rr_arbiter #(R) is the natural split.
  - Inputs: req [R], ptr [IW].
  - Outputs: combinational one-hot grant [R] and grant_idx [IW].
- The FSM, job registers and rr_ptr live in the top module.

## Test plan
- R=4, N=8, single job on req[2], start=10, end=14, up → done[2] at cycle 7. cnt_value sequence in RUN is 10..14. aborted = 0.
- Wrap job: start=250, end=3, up → 9 increments through 255→0. Then start=2, end=254, down → 4 decrements. Both complete.
- All four req high from reset → grants in order 0,1,2,3. Re-raise req[0] and req[3] after grant 1 → next grants are 3 then 0.
- start == end = 0x55 → LOAD, a single RUN cycle, then done 3 cycles after the request.
- Pause for 3 cycles mid-job (start=0, end=5, up) → cnt_en low for exactly those cycles; done arrives 3 cycles later than the unpaused case.
- abort in the 2nd RUN cycle → done pulses with aborted = 1 and no further cnt_en. Separately, reset_n asserted mid-RUN → all outputs are 0 immediately and no done pulse occurs.
